traffic_request_conditioner: RTL and testbench

- Front end for the intersection light controller; produces its car-sensor (i1/i2) and pedestrian-button (b1..b4) inputs.
- Synchronizes and debounces raw field inputs.
- Latches pedestrian presses as held requests.
- Clears a request only when the controller's walk-light feedback shows that crosswalk was served.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_request_conditioner_debounce_cell.sv | 43 ++++
 rtl/traffic_request_conditioner.sv | 119 +++++++++++
 tb/tb_traffic_request_conditioner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants for the intersection front end: field bit positions,
// crosswalk groups and the button/walk-light masks that tie them together.
package traffic_pkg;

    localparam int BTN_B1 = 0;
    localparam int BTN_B2 = 1;
    localparam int BTN_B3 = 2;
    localparam int BTN_B4 = 3;

    localparam int CAR_MAIN = 0;
    localparam int CAR_SIDE = 1;

    localparam int WALK_W1 = 0;
    localparam int WALK_W2 = 1;
    localparam int WALK_W3 = 2;
    localparam int WALK_W4 = 3;

    typedef enum logic {
        GRP_WE = 1'b0,
        GRP_NS = 1'b1
    } grp_e;

    // West-east pedestrians (b1, b3) cross while w2/w4 are lit; north-south the reverse.
    localparam logic [3:0] WE_BTN_MASK  = 4'b0101;
    localparam logic [3:0] NS_BTN_MASK  = 4'b1010;
    localparam logic [3:0] WE_WALK_MASK = 4'b1010;
    localparam logic [3:0] NS_WALK_MASK = 4'b0101;

    function automatic logic [3:0] grp_btn_mask(input grp_e grp);
        return (grp == GRP_WE) ? WE_BTN_MASK : NS_BTN_MASK;
    endfunction

endpackage

// File: rtl/traffic_request_conditioner_debounce_cell.sv
// One field input: two-flop synchronizer, then a level is accepted only after
// holding for DEBOUNCE_CYCLES consecutive synchronized cycles.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_62,
    input  logic rst_62,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // rise is a registered one-cycle pulse following the edge where stable goes high
    always_ff @(posedge clk_62 or posedge rst_62) begin
        if (rst_62) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                rise   <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions raw car sensors and pedestrian buttons for the light controller;
// optional REQ_TIMEOUT_EN drops requests left unserved for TIMEOUT_CYCLES.
module traffic_request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk_62,
    input  logic       rst_62,
    input  logic [3:0] raw_btn_62,
    input  logic [1:0] raw_car_62,
    input  logic [3:0] walk_62,
    output logic [3:0] b_62,
    output logic [1:0] i_62,
    output logic [1:0] req_pend_62
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    logic [5:0] raw_all;
    logic [5:0] stable_all;
    logic [5:0] rise_all;

    assign raw_all = {raw_car_62, raw_btn_62};

    for (genvar k = 0; k < 6; k++) begin : g_dbc
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_dbc (
            .clk_62 (clk_62),
            .rst_62 (rst_62),
            .raw    (raw_all[k]),
            .stable (stable_all[k]),
            .rise   (rise_all[k])
        );
    end

    // Cars only need the level, buttons only the press pulse.
    assign i_62 = stable_all[5:4];

    logic unused_cell_bits;
    assign unused_cell_bits = ^{stable_all[3:0], rise_all[5:4]};

    logic [1:0] walk_now;
    logic [1:0] walk_prev;
    logic [1:0] walk_fall;
    logic [1:0] grp_clear;
    logic [3:0] btn_clear;

    assign walk_now[GRP_WE] = |(walk_62 & WE_WALK_MASK);
    assign walk_now[GRP_NS] = |(walk_62 & NS_WALK_MASK);
    assign walk_fall        = walk_prev & ~walk_now;

    assign req_pend_62[GRP_WE] = |(b_62 & WE_BTN_MASK);
    assign req_pend_62[GRP_NS] = |(b_62 & NS_BTN_MASK);

    always_ff @(posedge clk_62 or posedge rst_62) begin
        if (rst_62) begin
            walk_prev <= '0;
        end else begin
            walk_prev <= walk_now;
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt [2];
    logic [1:0]    to_hit;

    always_comb begin
        to_hit = '0;
        for (int g = 0; g < 2; g++) begin
            to_hit[g] = req_pend_62[g] && !walk_now[g] &&
                        (to_cnt[g] == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    assign grp_clear = walk_fall | to_hit;

    // Age counts only quiet cycles: a pending request with its walk light dark.
    always_ff @(posedge clk_62 or posedge rst_62) begin
        if (rst_62) begin
            for (int g = 0; g < 2; g++) begin
                to_cnt[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (grp_clear[g] || walk_now[g] || !req_pend_62[g]) begin
                    to_cnt[g] <= '0;
                end else begin
                    to_cnt[g] <= to_cnt[g] + TW'(1);
                end
            end
        end
    end
`else
    assign grp_clear = walk_fall;
`endif

    assign btn_clear = ({4{grp_clear[GRP_WE]}} & grp_btn_mask(GRP_WE)) |
                       ({4{grp_clear[GRP_NS]}} & grp_btn_mask(GRP_NS));

    // A fresh press outranks a clear landing on the same edge.
    always_ff @(posedge clk_62 or posedge rst_62) begin
        if (rst_62) begin
            b_62 <= '0;
        end else begin
            b_62 <= rise_all[3:0] | (b_62 & ~btn_clear);
        end
    end

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed scenarios then random traffic, all checked against a history-based
// model of the request conditioner's rules.
module tb_traffic_request_conditioner;

    localparam int D    = 4;
    localparam int T    = 16;
    localparam int MAXE = 4096;

    logic       clk_62 = 1'b0;
    logic       rst_62;
    logic [3:0] raw_btn_62;
    logic [1:0] raw_car_62;
    logic [3:0] walk_62;
    logic [3:0] b_62;
    logic [1:0] i_62;
    logic [1:0] req_pend_62;

    traffic_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_62      (clk_62),
        .rst_62      (rst_62),
        .raw_btn_62  (raw_btn_62),
        .raw_car_62  (raw_car_62),
        .walk_62     (walk_62),
        .b_62        (b_62),
        .i_62        (i_62),
        .req_pend_62 (req_pend_62)
    );

    always #5 clk_62 = ~clk_62;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-edge history since the bench started; f marks the first edge after reset.
    int         n = 0;
    int         f = 0;
    logic [5:0] rawh  [MAXE];
    logic [5:0] stabh [MAXE];
    logic [1:0] walkh [MAXE];
    logic [1:0] pendh [MAXE];
    logic [1:0] clrh  [MAXE];
    logic [3:0] exp_b = '0;
    logic [1:0] exp_i = '0;

    function automatic logic [1:0] groupWalk(input logic [3:0] w);
        return {|(w & 4'b0101), |(w & 4'b1010)};
    endfunction

    function automatic logic [1:0] groupReq(input logic [3:0] b);
        return {|(b & 4'b1010), |(b & 4'b0101)};
    endfunction

    function automatic logic syncv(input int j, input int t);
        if (t - 2 >= f) return rawh[t-2][j];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // A level is accepted once the synchronized input has disagreed with the
    // accepted level on each of the last D edges.
    task automatic modelEdge();
        int         m;
        logic [5:0] prev, nxt;
        logic [1:0] gw, pend, wf, hit, clr;
        logic [3:0] rose, clrmask;
        bit         ok;
        m = n;
        if (m >= MAXE) begin
            $display("[TB] FAIL history: observed edge %0d expected below %0d", m, MAXE);
            $fatal(1, "[TB] history exhausted");
        end
        rawh[m]  = {raw_car_62, raw_btn_62};
        gw       = groupWalk(walk_62);
        walkh[m] = gw;
        prev = (m > f) ? stabh[m-1] : 6'b0;
        nxt  = prev;
        if (m - D + 1 >= f) begin
            for (int j = 0; j < 6; j++) begin
                ok = 1'b1;
                for (int t = m - D + 1; t <= m; t++) begin
                    if (syncv(j, t) == prev[j]) ok = 1'b0;
                end
                if (ok) nxt[j] = ~prev[j];
            end
        end
        stabh[m] = nxt;
        rose = 4'b0;
        if (m - 1 >= f) rose = stabh[m-1][3:0] & ~((m - 2 >= f) ? stabh[m-2][3:0] : 4'b0);
        pend     = groupReq(exp_b);
        pendh[m] = pend;
        wf = 2'b0;
        if (m - 1 >= f) wf = walkh[m-1] & ~gw;
        hit = 2'b0;
`ifdef REQ_TIMEOUT_EN
        for (int g = 0; g < 2; g++) begin
            if (pend[g] && !gw[g] && (m - T + 1 >= f)) begin
                ok = 1'b1;
                for (int t = m - T + 1; t < m; t++) begin
                    if (!pendh[t][g] || walkh[t][g] || clrh[t][g]) ok = 1'b0;
                end
                hit[g] = ok;
            end
        end
`endif
        clr     = wf | hit;
        clrh[m] = clr;
        clrmask = (clr[0] ? 4'b0101 : 4'b0000) | (clr[1] ? 4'b1010 : 4'b0000);
        exp_b   = rose | (exp_b & ~clrmask);
        exp_i   = nxt[5:4];
        n++;
    endtask

    task automatic checkOutput();
        chk("i_62", {2'b00, i_62}, {2'b00, exp_i});
        chk("b_62", b_62, exp_b);
        chk("req_pend_62", {2'b00, req_pend_62}, {2'b00, groupReq(exp_b)});
    endtask

    task automatic applyStimulus(input logic [3:0] btn, input logic [1:0] car,
                                 input logic [3:0] walk, input int cycles);
        raw_btn_62 = btn;
        raw_car_62 = car;
        walk_62    = walk;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_62);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    task automatic doReset();
        rst_62     = 1'b1;
        raw_btn_62 = '0;
        raw_car_62 = '0;
        walk_62    = '0;
        #1;
        chk("reset b_62", b_62, 4'b0000);
        chk("reset i_62", {2'b00, i_62}, 4'b0000);
        chk("reset req_pend_62", {2'b00, req_pend_62}, 4'b0000);
        exp_b = '0;
        exp_i = '0;
        repeat (2) @(posedge clk_62);
        #1;
        rst_62 = 1'b0;
        f      = n;
    endtask

    initial begin
        logic [3:0] rbtn;
        logic [1:0] rcar;
        logic [3:0] rwalk;

        doReset();

        // Bouncy side-street sensor: runs of 3 never qualify
        applyStimulus(4'b0000, 2'b10, 4'b0000, 3);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        applyStimulus(4'b0000, 2'b10, 4'b0000, 3);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("bounce i_62", {2'b00, i_62}, 4'b0000);
        applyStimulus(4'b0000, 2'b10, 4'b0000, 5);
        chk("car edge-5 i_62", {2'b00, i_62}, 4'b0000);
        applyStimulus(4'b0000, 2'b10, 4'b0000, 1);
        chk("car edge-6 i_62", {2'b00, i_62}, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 8);

        // Clean press of b1, then release keeps the request
        applyStimulus(4'b0001, 2'b00, 4'b0000, 6);
        chk("press edge-6 b_62", b_62, 4'b0000);
        applyStimulus(4'b0001, 2'b00, 4'b0000, 1);
        chk("press edge-7 b_62", b_62, 4'b0001);
        applyStimulus(4'b0001, 2'b00, 4'b0000, 2);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 10);
        chk("release b_62", b_62, 4'b0001);
        applyStimulus(4'b0000, 2'b00, 4'b1010, 1);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("we clear b_62", b_62, 4'b0000);

        // Service of the WE group
        applyStimulus(4'b0101, 2'b00, 4'b0000, 8);
        chk("we latched b_62", b_62, 4'b0101);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        applyStimulus(4'b0000, 2'b00, 4'b1010, 5);
        chk("we walking b_62", b_62, 4'b0101);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("we served b_62", b_62, 4'b0000);

        // Other group's walk leaves b2 alone; its own walk end clears it
        applyStimulus(4'b0010, 2'b00, 4'b0000, 8);
        chk("ns latched b_62", b_62, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        applyStimulus(4'b0000, 2'b00, 4'b1010, 2);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("ns untouched b_62", b_62, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0101, 3);
        chk("ns walking b_62", b_62, 4'b0010);
        chk("ns walking req_pend_62", {2'b00, req_pend_62}, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("ns served b_62", b_62, 4'b0000);

        // b3 press lands on the WE walk falling edge with b1 pending
        applyStimulus(4'b0001, 2'b00, 4'b0000, 8);
        chk("setwins pre b_62", b_62, 4'b0001);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        applyStimulus(4'b0100, 2'b00, 4'b1010, 6);
        applyStimulus(4'b0100, 2'b00, 4'b0000, 1);
        chk("setwins b_62", b_62, 4'b0100);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 6);
        applyStimulus(4'b0000, 2'b00, 4'b1010, 1);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("setwins cleared b_62", b_62, 4'b0000);

        // Unserved b2 request
        applyStimulus(4'b0010, 2'b00, 4'b0000, 7);
        chk("idle latched b_62", b_62, 4'b0010);
`ifdef REQ_TIMEOUT_EN
        applyStimulus(4'b0000, 2'b00, 4'b0000, 15);
        chk("timeout edge-15 b_62", b_62, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
        chk("timeout b_62", b_62, 4'b0000);
        chk("timeout req_pend_62", {2'b00, req_pend_62}, 4'b0000);
`else
        applyStimulus(4'b0000, 2'b00, 4'b0000, 100);
        chk("hold b_62", b_62, 4'b0010);
        chk("hold req_pend_62", {2'b00, req_pend_62}, 4'b0010);
        applyStimulus(4'b0000, 2'b00, 4'b0101, 1);
        applyStimulus(4'b0000, 2'b00, 4'b0000, 1);
`endif

        // Reset mid-operation with requests and cars present
        applyStimulus(4'b0101, 2'b11, 4'b0000, 8);
        chk("pre-reset b_62", b_62, 4'b0101);
        chk("pre-reset i_62", {2'b00, i_62}, 4'b0011);
        doReset();

        // Random traffic against the model
        rbtn  = '0;
        rcar  = '0;
        rwalk = '0;
        for (int r = 0; r < 600; r++) begin
            if ($urandom_range(4) == 0) rbtn ^= 4'(1 << $urandom_range(3));
            if ($urandom_range(5) == 0) rcar ^= 2'(1 << $urandom_range(1));
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(2))
                    0:       rwalk = 4'b1010;
                    1:       rwalk = 4'b0101;
                    default: rwalk = 4'b0000;
                endcase
            end
            applyStimulus(rbtn, rcar, rwalk, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
